// File: rtl/byte_inc_job_queue.sv
//------------------------------------------------------------------------------
// Module      : byte_inc_job_queue
// Description : Job FIFO and dispatcher feeding byte_inc's settings port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module byte_inc_job_queue #(
   parameter int ADDR_WIDTH  = 10,
   parameter int LEN_WIDTH   = 13,
   parameter int DEPTH       = 8,
   parameter int ACK_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                       clk_i,
   input  logic                       arst_n_i,
   input  logic                       job_valid_i,
   output logic                       job_ready_o,
   input  logic [ADDR_WIDTH-1:0]      job_base_addr_i,
   input  logic [LEN_WIDTH-1:0]       job_length_i,
   output logic [ADDR_WIDTH-1:0]      base_addr_o,
   output logic [LEN_WIDTH-1:0]       length_o,
   output logic                       run_o,
   input  logic                       waitrequest_i,
   output logic                       busy_o,
   output logic [$clog2(DEPTH):0]     pending_o,
   output logic                       done_pulse_o,
   output logic [CNT_WIDTH-1:0]       done_cnt_o,
   output logic [CNT_WIDTH-1:0]       drop_cnt_o,
   output logic                       err_o
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_TMR_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_ACK  = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [ADDR_WIDTH-1:0]  r_mem_base [DEPTH];
   logic [LEN_WIDTH-1:0]   r_mem_len  [DEPTH];
   logic [c_PTR_W-1:0]     r_wr_ptr;
   logic [c_PTR_W-1:0]     r_rd_ptr;
   logic [c_CNT_W-1:0]     r_count;
   logic [c_TMR_W-1:0]     r_timer;
   logic [ADDR_WIDTH-1:0]  r_base_addr;
   logic [LEN_WIDTH-1:0]   r_length;
   logic                   r_done_pulse;
   logic [CNT_WIDTH-1:0]   r_done_cnt;
   logic [CNT_WIDTH-1:0]   r_drop_cnt;
   logic                   r_err;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_head_zero;
   logic w_timeout;
   logic w_done;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == c_CNT_W'(DEPTH));
   // Ready is held low while reset is asserted so nothing is offered into a clearing FIFO
   assign job_ready_o = arst_n_i && !w_full;
   assign w_push      = job_valid_i && job_ready_o;
   assign w_pop       = (r_state == S_IDLE) && !w_empty && !waitrequest_i;
   assign w_head_zero = (r_mem_len[r_rd_ptr] == '0);

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_base[r_wr_ptr] <= job_base_addr_i;
         r_mem_len[r_wr_ptr]  <= job_length_i;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_timeout    = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pop && !w_head_zero) w_next_state = S_ISSUE;
         end
         S_ISSUE: begin
            w_next_state = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (waitrequest_i) begin
               w_next_state = S_WAIT_DONE;
            end else if (r_timer == c_TMR_W'(ACK_TIMEOUT - 1)) begin
               w_timeout    = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (!waitrequest_i) begin
               w_done       = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state      <= S_IDLE;
         r_timer      <= '0;
         r_base_addr  <= '0;
         r_length     <= '0;
         r_done_pulse <= 1'b0;
         r_done_cnt   <= '0;
         r_drop_cnt   <= '0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         // Timer only runs in WAIT_ACK; ISSUE always leaves it at zero
         r_timer      <= (r_state == S_WAIT_ACK) ? r_timer + 1'b1 : '0;
         r_done_pulse <= w_done;
         if (w_pop && !w_head_zero) begin
            r_base_addr <= r_mem_base[r_rd_ptr];
            r_length    <= r_mem_len[r_rd_ptr];
         end
         if (w_pop && w_head_zero) r_drop_cnt <= r_drop_cnt + 1'b1;
         if (w_done)               r_done_cnt <= r_done_cnt + 1'b1;
         if (w_timeout)            r_err      <= 1'b1;
      end
   end

   assign base_addr_o  = r_base_addr;
   assign length_o     = r_length;
   assign run_o        = (r_state == S_ISSUE);
   assign busy_o       = (r_state != S_IDLE);
   assign pending_o    = r_count;
   assign done_pulse_o = r_done_pulse;
   assign done_cnt_o   = r_done_cnt;
   assign drop_cnt_o   = r_drop_cnt;
   assign err_o        = r_err;

endmodule

`default_nettype wire
